// File: rtl/d3s_pkg.sv
// Shared types and constants for the D3S RF counter and its neighbours.
package d3s_pkg;

  localparam int c_D3S_CYCLES_PER_SEC = 125000000;
  localparam int c_D3S_CNT_WIDTH      = 32;
  localparam int c_D3S_CYCLES_WIDTH   = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } t_rf_sync_state;

  typedef struct packed {
    logic [c_D3S_CNT_WIDTH-1:0]    rf;
    logic [c_D3S_CYCLES_WIDTH-1:0] cycles;
    logic                          valid;
    logic                          overrun;
  } t_rf_cnt_snapshot;

endpackage

// File: rtl/d3s_mod_counter.sv
// Modulo accumulator: adds an increment to the count (or to a load value),
// wrapping by an optional period; period 0 wraps naturally at 2^g_width.
module d3s_mod_counter #(
  parameter int g_width     = 32,
  parameter int g_inc_width = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [g_inc_width-1:0] inc,
  input  logic                   load,
  input  logic [g_width-1:0]     load_value,
  input  logic [g_width-1:0]     period,
  output logic [g_width-1:0]     cnt,
  output logic                   wrap
);

  logic [g_width-1:0] base;
  logic [g_width:0]   sum;
  logic [g_width-1:0] cnt_next;
  logic               wrap_next;

  // One extra bit keeps the period compare exact even near full scale.
  always_comb begin
    base      = load ? load_value : cnt;
    sum       = {1'b0, base} + (g_width+1)'(inc);
    cnt_next  = sum[g_width-1:0];
    wrap_next = 1'b0;
    if (period != '0 && sum >= {1'b0, period}) begin
      cnt_next  = g_width'(sum - {1'b0, period});
      wrap_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: rtl/d3s_rf_cnt_sync.sv
// RF edge counter with timed sync load and sample-strobe snapshots,
// running entirely in the WR reference clock domain.
module d3s_rf_cnt_sync
  import d3s_pkg::*;
#(
  parameter int g_cnt_width      = 32,
  parameter int g_cycles_width   = 28,
  parameter int g_cycles_per_sec = c_D3S_CYCLES_PER_SEC
) (
  input  logic                      clk_ref_i,
  input  logic                      rst_n_i,
  input  logic                      enable_i,
  input  logic [1:0]                rf_edges_i,
  input  logic [g_cycles_width-1:0] tm_cycles_i,
  input  logic [g_cnt_width-1:0]    period_i,
  input  logic [g_cnt_width-1:0]    sync_value_i,
  input  logic [g_cycles_width-1:0] trig_cycles_i,
  input  logic                      arm_load_i,
  input  logic                      disarm_i,
  input  logic                      sample_p_i,
  input  logic                      snap_ack_i,
  output logic [g_cnt_width-1:0]    rf_cnt_o,
  output logic                      rf_rst_o,
  output logic [g_cnt_width-1:0]    snap_rf_o,
  output logic [g_cycles_width-1:0] snap_cycles_o,
  output logic                      snap_valid_o,
  output logic                      snap_overrun_o,
  output logic                      armed_o,
  output logic                      done_o,
  output logic                      arm_err_o
);

  localparam logic [g_cycles_width:0] c_cycles_limit = (g_cycles_width+1)'(g_cycles_per_sec);

  t_rf_sync_state   state, state_next;
  t_rf_cnt_snapshot snap;
  logic             arm_err, arm_err_next;
  logic             arm_legal;
  logic             load;
  logic [g_cnt_width-1:0] rf_cnt;

  d3s_mod_counter #(
    .g_width     (g_cnt_width),
    .g_inc_width (2)
  ) u_counter (
    .clk        (clk_ref_i),
    .rst_n      (rst_n_i),
    .clr        (!enable_i),
    .inc        (rf_edges_i),
    .load       (load),
    .load_value (sync_value_i),
    .period     (period_i),
    .cnt        (rf_cnt),
    .wrap       (rf_rst_o)
  );

  assign arm_legal = {1'b0, trig_cycles_i} < c_cycles_limit;

  always_comb begin
    state_next   = state;
    load         = 1'b0;
    arm_err_next = arm_err;
    if (arm_load_i)
      arm_err_next = !arm_legal;
    case (state)
      IDLE: begin
        if (arm_load_i && arm_legal && !disarm_i)
          state_next = ARMED;
      end
      ARMED: begin
        // Disarm has priority over a coincident trigger match.
        if (disarm_i)
          state_next = IDLE;
        else if (tm_cycles_i == trig_cycles_i) begin
          state_next = DONE;
          load       = 1'b1;
        end
      end
      DONE: begin
        if (arm_load_i && disarm_i)
          state_next = IDLE;
        else if (arm_load_i && arm_legal)
          state_next = ARMED;
      end
      default: state_next = IDLE;
    endcase
    if (!enable_i) begin
      state_next = IDLE;
      load       = 1'b0;
    end
  end

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      arm_err <= 1'b0;
    end else begin
      state   <= state_next;
      arm_err <= arm_err_next;
    end
  end

  // Snapshot captures the count before this cycle's update.
  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      snap <= '0;
    end else if (sample_p_i) begin
      snap.rf      <= c_D3S_CNT_WIDTH'(rf_cnt);
      snap.cycles  <= c_D3S_CYCLES_WIDTH'(tm_cycles_i);
      snap.valid   <= 1'b1;
      snap.overrun <= snap_ack_i ? 1'b0 : (snap.overrun | snap.valid);
    end else if (snap_ack_i) begin
      snap.valid   <= 1'b0;
      snap.overrun <= 1'b0;
    end
  end

  assign rf_cnt_o       = rf_cnt;
  assign snap_rf_o      = g_cnt_width'(snap.rf);
  assign snap_cycles_o  = g_cycles_width'(snap.cycles);
  assign snap_valid_o   = snap.valid;
  assign snap_overrun_o = snap.overrun;
  assign armed_o        = (state == ARMED);
  assign done_o         = (state == DONE);
  assign arm_err_o      = arm_err;

endmodule

// File: doc/d3s_rf_cnt_sync.md
Name: d3s_rf_cnt_sync

Overview:
- RF cycle counter for the D3S core, in the WR reference clock domain.
- Sits directly downstream of the synthesized-clock edge detector and upstream of the host CSR block.
- Counts RF edges modulo a programmable period and latches RF-count/TAI-cycle snapshots on each phase-detector sample strobe.
- Reloads the count with a sync value at a programmed TAI cycle. This lets a slave node lock its RF counter to a master's.

Parameters:
- g_cnt_width, 32, width of RF counter, period, sync value and RF snapshot.
- g_cycles_width, 28, width of the WR cycle counter.
- g_cycles_per_sec, 125000000, cycles per TAI second; trigger values at or above this are illegal.

Ports:
- clk_ref_i  in  1  WR reference clock (125 MHz); the only clock.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  counter enable (CR.RF_CNT_ENABLE).
- rf_edges_i  in  2  RF rising edges seen this clk_ref_i cycle (0..2).
- tm_cycles_i  in  g_cycles_width  WR cycle counter.
- period_i  in  g_cnt_width  wrap period; 0 means free-running with natural 2^g_cnt_width wrap.
- sync_value_i  in  g_cnt_width  value loaded at trigger.
- trig_cycles_i  in  g_cycles_width  TAI cycle at which to load.
- arm_load_i  in  1  one-cycle pulse: arm the timed load.
- disarm_i  in  1  one-cycle pulse: cancel the armed load.
- sample_p_i  in  1  sample strobe from the phase-detector prescaler.
- snap_ack_i  in  1  one-cycle pulse: host consumed the snapshot.
- rf_cnt_o  out  g_cnt_width  live count.
- rf_rst_o  out  1  one-cycle pulse on wrap.
- snap_rf_o  out  g_cnt_width  latched RF count.
- snap_cycles_o  out  g_cycles_width  latched tm_cycles_i.
- snap_valid_o  out  1  snapshot pending.
- snap_overrun_o  out  1  sticky: sample arrived while snapshot pending.
- armed_o  out  1  load armed.
- done_o  out  1  load executed.
- arm_err_o  out  1  sticky: arm with illegal trigger value.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE.
- Count update, registered with 1-cycle latency: n = cnt + rf_edges_i.
  - If period_i != 0 and n >= period_i: cnt <= n - period_i and rf_rst_o = 1 for that cycle.
  - Otherwise cnt <= n.
  - Compare with g_cnt_width+1 bits so n never overflows.
- enable_i = 0: cnt held at 0, rf_rst_o = 0, FSM forced to IDLE, done_o cleared. Snapshot logic keeps operating.
- Lowering period_i below the current cnt: the next update subtracts period_i once per cycle. It never resets cnt to 0 directly.
- FSM states:
  - IDLE -> ARMED on arm_load_i when trig_cycles_i < g_cycles_per_sec. done_o is cleared.
  - IDLE -> IDLE with arm_err_o set if trig_cycles_i >= g_cycles_per_sec.
  - ARMED -> IDLE on disarm_i.
  - ARMED -> DONE when tm_cycles_i == trig_cycles_i. That cycle cnt <= (sync_value_i + rf_edges_i), wrapped by period_i as above. The load overrides the normal increment. rf_rst_o = 1 only if the wrap occurs.
  - DONE -> ARMED on a new arm_load_i. done_o = 1 while in DONE.
- The match is evaluated only in cycles after ARMED is entered. An arm pulse coinciding with the matching cycle does not fire until the next second.
- arm_load_i and disarm_i in the same cycle: disarm wins and the state is IDLE.
- trig_cycles_i is sampled continuously while ARMED. The host must not change it while armed.
- Snapshot, on sample_p_i:
  - snap_rf_o <= cnt as it is before this cycle's update.
  - snap_cycles_o <= tm_cycles_i.
  - snap_valid_o <= 1.
- If snap_valid_o is already 1 on sample_p_i: the snapshot is overwritten and snap_overrun_o is set.
- snap_ack_i clears snap_valid_o and snap_overrun_o. If snap_ack_i and sample_p_i coincide, the sample wins: valid = 1 and overrun is cleared.
- arm_err_o is cleared by the next legal arm.
- Asynchronous reset mid-operation returns to the reset state immediately. An armed load is lost.

Decomposition:
- Shared package d3s_pkg:
  - constant c_D3S_CYCLES_PER_SEC;
  - FSM enum t_rf_sync_state (IDLE, ARMED, DONE);
  - record t_rf_cnt_snapshot (rf, cycles, valid, overrun).
- One natural sub-module: d3s_mod_counter, a modulo accumulator taking increment, optional load value and period, and producing cnt and a wrap pulse. It is reused by the DDS sample-index counter.

Test Plan:
- Counting and wrap: period_i = 10, rf_edges_i = 2 every cycle, enable_i = 1. Expect rf_cnt_o sequence 2,4,6,8,0 with rf_rst_o on the 0, then 2.
- Free-running wrap: period_i = 0, cnt forced near 0xFFFFFFFF via sync load, rf_edges_i = 2. Expect wrap to 0 and 1, with rf_rst_o = 0.
- Timed load: period_i = 100000, sync_value_i = 5000, trig_cycles_i = 1000, arm at tm_cycles_i = 900, rf_edges_i = 1. Expect armed_o = 1 at cycle 901. At tm_cycles_i = 1000 the count loads so that rf_cnt_o = 5001 one cycle later. Then done_o = 1 and armed_o = 0.
- Illegal arm and disarm:
  - arm with trig_cycles_i = 125000000 -> arm_err_o = 1, armed_o = 0;
  - legal arm then disarm_i -> armed_o = 0 and no load at the match cycle.
- Snapshot and overrun:
  - sample_p_i at tm_cycles_i = 12500 with cnt = 777 -> snap_rf_o = 777, snap_cycles_o = 12500, snap_valid_o = 1;
  - a second sample without ack -> snap_overrun_o = 1;
  - snap_ack_i -> both flags cleared.
- Enable and reset mid-operation:
  - drop enable_i while ARMED -> rf_cnt_o = 0 and armed_o = 0;
  - assert rst_n_i = 0 mid-count -> all outputs 0 asynchronously.
